// File: rtl/present_decrypt_core.sv
// PRESENT-80 decryption core: replays the key schedule forward to K32, then runs 31 inverse rounds.
// Optional key cache (skips the forward replay on a repeated key) enabled by PRESENT_DEC_KEYCACHE_EN.
module present_decrypt_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [63:0] ciphertext_i,
  input  logic [79:0] key_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [63:0] plaintext_o
);

  typedef enum logic [1:0] {StIdle, StKeyFwd, StDecrypt, StDone} state_e;

  // Nibble x of each table is S(x) / S^-1(x).
  localparam logic [63:0] Sbox    = 64'h21748FE3DA09B65C;
  localparam logic [63:0] SboxInv = 64'hA970364BD21C8FE5;

  state_e      st_q;
  logic [63:0] state_q;
  logic [79:0] key_q;
  logic [4:0]  cnt_q;
  logic [79:0] key_fwd;
  logic [79:0] key_prev;
  logic [63:0] state_dec;

  function automatic logic [79:0] key_update_fwd(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = {k[18:0], k[79:19]};
    r[79:76]   = Sbox[{r[79:76], 2'b00} +: 4];
    r[19:15]   = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [79:0] key_update_inv(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    r          = k;
    r[19:15]   = r[19:15] ^ rc;
    r[79:76]   = SboxInv[{r[79:76], 2'b00} +: 4];
    return {r[60:0], r[79:61]};
  endfunction

  // Inverse permutation followed by the inverse S-box layer.
  function automatic logic [63:0] dec_layer(input logic [63:0] s);
    logic [63:0] p;
    logic [63:0] o;
    for (int k = 0; k < 63; k++) begin
      p[k] = s[(16 * k) % 63];
    end
    p[63] = s[63];
    for (int n = 0; n < 16; n++) begin
      o[4*n +: 4] = SboxInv[{p[4*n +: 4], 2'b00} +: 4];
    end
    return o;
  endfunction

  always_comb begin
    key_fwd   = key_update_fwd(key_q, cnt_q);
    key_prev  = key_update_inv(key_q, cnt_q);
    state_dec = dec_layer(state_q) ^ key_prev[79:16];
  end

`ifdef PRESENT_DEC_KEYCACHE_EN
  logic [79:0] cached_key_q;
  logic [79:0] cached_k32_q;
  logic        cache_valid_q;
  logic        cache_hit;

  assign cache_hit = cache_valid_q && (key_i == cached_key_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q          <= StIdle;
      state_q       <= '0;
      key_q         <= '0;
      cnt_q         <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      plaintext_o   <= '0;
`ifdef PRESENT_DEC_KEYCACHE_EN
      cached_key_q  <= '0;
      cached_k32_q  <= '0;
      cache_valid_q <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (st_q)
        StIdle: begin
          if (start_i) begin
            busy_o <= 1'b1;
`ifdef PRESENT_DEC_KEYCACHE_EN
            if (cache_hit) begin
              key_q   <= cached_k32_q;
              state_q <= ciphertext_i ^ cached_k32_q[79:16];
              cnt_q   <= 5'd31;
              st_q    <= StDecrypt;
            end else begin
              state_q       <= ciphertext_i;
              key_q         <= key_i;
              cnt_q         <= 5'd1;
              st_q          <= StKeyFwd;
              // Captured key is held here but only trusted once K32 is stored.
              cached_key_q  <= key_i;
              cache_valid_q <= 1'b0;
            end
`else
            state_q <= ciphertext_i;
            key_q   <= key_i;
            cnt_q   <= 5'd1;
            st_q    <= StKeyFwd;
`endif
          end
        end
        StKeyFwd: begin
          key_q <= key_fwd;
          if (cnt_q == 5'd31) begin
            state_q <= state_q ^ key_fwd[79:16];
            st_q    <= StDecrypt;
`ifdef PRESENT_DEC_KEYCACHE_EN
            cached_k32_q  <= key_fwd;
            cache_valid_q <= 1'b1;
`endif
          end else begin
            cnt_q <= cnt_q + 5'd1;
          end
        end
        StDecrypt: begin
          state_q <= state_dec;
          key_q   <= key_prev;
          cnt_q   <= cnt_q - 5'd1;
          if (cnt_q == 5'd1) begin
            st_q        <= StDone;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
            plaintext_o <= state_dec;
          end
        end
        StDone:  st_q <= StIdle;
        default: st_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_present_decrypt_core.sv
// Self-checking bench for present_decrypt_core: ciphertexts come from a PRESENT-80 encryption model,
// and a per-cycle transaction model predicts busy_o, done_o and plaintext_o.
module tb_present_decrypt_core;

`ifdef PRESENT_DEC_KEYCACHE_EN
  localparam bit CacheEn = 1'b1;
`else
  localparam bit CacheEn = 1'b0;
`endif

  localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                     4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [63:0] ciphertext_i;
  logic [79:0] key_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] plaintext_o;

  logic [63:0] tb_pt;
  logic [79:0] last_key;
  bit          lk_valid;
  int          errors = 0;
  int          checks = 0;

  present_decrypt_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .ciphertext_i (ciphertext_i),
    .key_i        (key_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .plaintext_o  (plaintext_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference PRESENT-80 encryption.
  function automatic logic [63:0] encrypt(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] s;
    logic [63:0] t;
    logic [79:0] k;
    logic [4:0]  rc;
    s = pt;
    k = key;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ k[79:16];
      for (int n = 0; n < 16; n++) t[4*n +: 4] = SB[t[0] ? s[4*n +: 4] : s[4*n +: 4]];
      for (int i = 0; i < 64; i++) s[(i == 63) ? 63 : (16 * i) % 63] = t[i];
      rc       = 5'(r);
      k        = {k[18:0], k[79:19]};
      k[79:76] = SB[k[79:76]];
      k[19:15] = k[19:15] ^ rc;
    end
    return s ^ k[79:16];
  endfunction

  function automatic int exp_lat(input logic [79:0] key);
    return (CacheEn && lk_valid && key == last_key) ? 31 : 62;
  endfunction

  // Transaction-level model: what the outputs must be in the cycle after each edge.
  int          m_st;
  int          m_left;
  logic        m_busy;
  logic        m_done;
  logic [63:0] m_pt;
  logic [63:0] m_res;
  logic [79:0] m_ck;
  logic        m_cv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= 0; m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0;
      m_pt <= '0; m_res <= '0; m_ck <= '0; m_cv <= 1'b0;
    end else begin
      case (m_st)
        0: if (start_i) begin
          m_res  <= tb_pt;
          m_busy <= 1'b1;
          m_st   <= 1;
          if (CacheEn && m_cv && key_i == m_ck) begin
            m_left <= 30;
          end else begin
            m_left <= 61;
            m_ck   <= key_i;
            m_cv   <= 1'b0;
          end
        end
        1: if (m_left == 0) begin
          m_st <= 2; m_busy <= 1'b0; m_done <= 1'b1; m_pt <= m_res; m_cv <= 1'b1;
        end else begin
          m_left <= m_left - 1;
        end
        default: begin
          m_st <= 0; m_done <= 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    checks++;
    if ({busy_o, done_o, plaintext_o} !== {m_busy, m_done, m_pt}) begin
      errors++;
      $display("FAIL cycle @%0t: busy/done/pt got %b/%b/%h want %b/%b/%h", $time,
               busy_o, done_o, plaintext_o, m_busy, m_done, m_pt);
    end
  end

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  // Counts edges after the accepting edge until done_o; optionally scribbles on inputs meanwhile.
  task automatic wait_done(input logic [63:0] ct, input logic [63:0] pt, input logic [79:0] key,
                           input bit noise, input bit hold, input int lat, input string name);
    int   n;
    logic seen;
    logic [31:0] r0, r1, r2;
    n    = 0;
    seen = 1'b0;
    while (n < 200 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (noise && n < 25) begin
        r0 = $urandom; r1 = $urandom; r2 = $urandom;
        ciphertext_i = {r1, r0};
        key_i        = {r2[15:0], r1, r0};
        start_i      = r2[31];
      end else begin
        ciphertext_i = ct;
        key_i        = key;
        start_i      = hold;
      end
      seen = done_o;
    end
    check_int({name, " latency"}, n, lat);
    check64({name, " plaintext"}, plaintext_o, pt);
    last_key = key;
    lk_valid = 1'b1;
  endtask

  task automatic do_op(input logic [63:0] ct, input logic [63:0] pt, input logic [79:0] key,
                       input bit noise, input string name);
    int lat;
    lat = exp_lat(key);
    @(posedge clk);
    #1;
    ciphertext_i = ct; key_i = key; tb_pt = pt; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(ct, pt, key, noise, 1'b0, lat, name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] ones;
    logic [79:0] kones;
    logic [79:0] k;
    logic [63:0] pt;
    logic [31:0] r0, r1, r2;
    int          lat;
    ones  = '1;
    kones = '1;
    rst_n = 1'b1; start_i = 1'b0; ciphertext_i = '0; key_i = '0; tb_pt = '0;
    lk_valid = 1'b0; last_key = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset outputs", {busy_o, done_o, plaintext_o[61:0]}, 64'h0);
    check64("reset plaintext", plaintext_o, 64'h0);
    rst_n = 1'b1;

    check64("model enc k0 p0", encrypt(64'h0, 80'h0), 64'h5579C1387B228445);
    check64("model enc k0 p1", encrypt(ones, 80'h0), 64'hA112FFC72F68417B);
    check64("model enc k1 p0", encrypt(64'h0, kones), 64'hE72C46C0F5945049);
    check64("model enc k1 p1", encrypt(ones, kones), 64'h3333DCD3213210D2);

    do_op(64'h5579C1387B228445, 64'h0, 80'h0, 1'b0, "k0 ct5579");
    do_op(64'h5579C1387B228445, 64'h0, 80'h0, 1'b0, "k0 repeat");
    do_op(64'hE72C46C0F5945049, 64'h0, kones, 1'b0, "k1 ctE72C");
    do_op(64'h3333DCD3213210D2, ones, kones, 1'b0, "k1 ct3333");
    do_op(64'hA112FFC72F68417B, ones, 80'h0, 1'b1, "k0 ctA112 noisy");

    // Start held high across completion is re-accepted in the first idle cycle.
    lat = exp_lat(80'h0);
    @(posedge clk);
    #1;
    ciphertext_i = 64'h5579C1387B228445; key_i = '0; tb_pt = '0; start_i = 1'b1;
    @(posedge clk);
    #1;
    wait_done(64'h5579C1387B228445, 64'h0, 80'h0, 1'b0, 1'b1, lat, "held first");
    lat = exp_lat(80'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(64'h5579C1387B228445, 64'h0, 80'h0, 1'b0, 1'b0, lat, "held second");

    // Reset in the middle of an operation.
    @(posedge clk);
    #1;
    ciphertext_i = 64'hA112FFC72F68417B; key_i = kones; tb_pt = ones; start_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check64("mid reset outputs", {busy_o, done_o, plaintext_o[61:0]}, 64'h0);
    lk_valid = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    do_op(64'h5579C1387B228445, 64'h0, 80'h0, 1'b0, "after reset");

    for (int i = 0; i < 16; i++) begin
      r0 = $urandom; r1 = $urandom; r2 = $urandom;
      pt = {r1, r0};
      k  = r2[0] ? last_key : {r2[31:16], $urandom, $urandom};
      do_op(encrypt(pt, k), pt, k, r2[1], $sformatf("random %0d", i));
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/present_decrypt_core.md
PRESENT_DECRYPT_CORE -- requirements
Module: present_decrypt_core

Interface
REQ-001 The block SHALL have no parameters; PRESENT-80 is fixed at 31 rounds, 64-bit block and 80-bit key.
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 Ports SHALL be:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start_i  input  1  request to decrypt; sampled only in IDLE
- ciphertext_i  input  64  ciphertext; captured on the accepting edge
- key_i  input  80  user key K[79:0]; captured on the accepting edge
- busy_o  output  1  high in KEYFWD and DECRYPT
- done_o  output  1  one-cycle pulse; plaintext_o valid
- plaintext_o  output  64  result; held until the next accepted start

Function
REQ-004 The FSM SHALL have the states IDLE, KEYFWD, DECRYPT and DONE, with these transitions:
- IDLE to KEYFWD on start_i=1
- KEYFWD to DECRYPT after 31 cycles
- DECRYPT to DONE after 31 cycles
- DONE to IDLE unconditionally
REQ-005 The accepting edge (E0) SHALL load state_reg=ciphertext_i, key_reg=key_i and round counter=1.
REQ-006 Each KEYFWD cycle SHALL apply the forward schedule to key_reg in this order, then increment the counter:
- rotate left 61
- [79:76]=S([79:76])
- [19:15]^=counter[4:0]
REQ-007 The last KEYFWD edge (counter=31) SHALL store K32 in key_reg, set state_reg = state_reg XOR new_key[79:16], and load counter=31.
REQ-008 Each DECRYPT cycle with counter i SHALL first compute prev = inverse schedule(key_reg, i):
- [19:15]^=i
- [79:76]=S^-1([79:76])
- rotate right 61
REQ-009 Each DECRYPT cycle SHALL then set state_reg = S^-1-layer(P^-1(state_reg)) XOR prev[79:16] and key_reg=prev, then decrement the counter.
REQ-010 P^-1 SHALL map input bit j to output bit k, where P(k)=j and P(k)=16k mod 63 for k<63, P(63)=63.
REQ-011 S^-1 SHALL be the nibble table 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A for inputs 0..F; it SHALL be applied to all 16 nibbles.
REQ-012 On the DECRYPT edge with counter=1, the block SHALL move to DONE and load plaintext_o=new state.
REQ-013 done_o SHALL be high exactly during the DONE cycle, which follows edge E62, 62 edges after E0.
REQ-014 start_i SHALL be ignored in KEYFWD, DECRYPT and DONE; it is not queued.
REQ-015 start_i held high continuously SHALL be re-accepted in the first IDLE cycle after DONE.
REQ-016 ciphertext_i and key_i changes after E0 SHALL NOT affect the result.

Reset
REQ-017 rst_n=0 SHALL immediately force the following, including mid-operation, with no output of the interrupted operation:
- state IDLE
- busy_o=0
- done_o=0
- plaintext_o=0
- state_reg, key_reg and counter cleared
REQ-018 After rst_n deasserts, the first start_i SHALL be accepted at the first rising edge with start_i=1.

Configuration
REQ-019 With macro PRESENT_DEC_KEYCACHE_EN defined, the block SHALL hold cached_key (80b), cached_k32 (80b) and cache_valid.
REQ-020 With the macro defined, the last KEYFWD edge SHALL store the captured key and K32 and set cache_valid=1.
REQ-021 With the macro defined, if start_i is accepted with cache_valid=1 and key_i==cached_key, then E0 SHALL do the following, giving done_o after E31:
- load key_reg=cached_k32
- load state_reg=ciphertext_i XOR cached_k32[79:16]
- load counter=31
- enter DECRYPT directly
REQ-022 With the macro defined, reset SHALL clear cache_valid.
REQ-023 Without the macro, none of the cache logic SHALL exist and every operation SHALL take the REQ-013 latency.

Verification
REQ-024 key=0, ct=5579C1387B228445 -> done_o after E62, plaintext_o=0000000000000000, busy_o high for 62 cycles.
REQ-025 key=FFFFFFFFFFFFFFFFFFFF, ct=E72C46C0F5945049 -> plaintext_o=0000000000000000; with key=FFFFFFFFFFFFFFFFFFFF, ct=3333DCD3213210D2 -> plaintext_o=FFFFFFFFFFFFFFFF.
REQ-026 key=0, ct=A112FFC72F68417B -> plaintext_o=FFFFFFFFFFFFFFFF; pulse start_i and change inputs during busy -> result unchanged, no extra done_o.
REQ-027 Assert rst_n=0 at edge E40 of an operation -> outputs 0 at once, no done_o; then a new start with REQ-024 vectors -> correct result at E62.
REQ-028 With PRESENT_DEC_KEYCACHE_EN: run REQ-024, then key=0, ct=5579C1387B228445 again -> done_o after E31 with the correct result; then a different key -> 62-edge latency.
